wb_burst_master: RTL and testbench

// - Wishbone B3 bus master: turns one command (addr, length, dir) into a single

---
 rtl/wb_burst_master_if.sv | 45 ++++
 rtl/wb_burst_master.sv | 152 +++++++++++++++
 tb/tb_wb_burst_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
// Command, write-data, read-data and Wishbone bus bundle for wb_burst_master.
// The master modport is the DUT side; slave is the user/bus-model side.
// Bus nets keep the slave-side _i/_o suffixes of the attached Wishbone port.
interface wb_burst_master_if #(
    parameter int DW    = 32,
    parameter int AW    = 26,
    parameter int LEN_W = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_we;
    logic [AW-1:0]      cmd_addr;
    logic [LEN_W-1:0]   cmd_len;
    logic [DW-1:0]      wdat;
    logic [DW/8-1:0]    wsel;
    logic               wdat_valid;
    logic               wdat_ready;
    logic [DW-1:0]      rdat;
    logic               rdat_valid;
    logic               done;
    logic               err;
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic               wb_we_i;
    logic [AW-1:0]      wb_addr_i;
    logic [DW-1:0]      wb_dat_i;
    logic [DW/8-1:0]    wb_sel_i;
    logic [2:0]         wb_cti_i;
    logic               wb_ack_o;
    logic [DW-1:0]      wb_dat_o;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wdat, wsel, wdat_valid,
               wb_ack_o, wb_dat_o,
        output cmd_ready, wdat_ready, rdat, rdat_valid, done, err,
               wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wdat, wsel, wdat_valid,
               wb_ack_o, wb_dat_o,
        input  cmd_ready, wdat_ready, rdat, rdat_valid, done, err,
               wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 master: one command becomes one cycle of 1..2^LEN_W beats (classic or incr burst).
// Latency: cyc rises the cycle after accept; rdat 1 cycle after ack; done the cycle after last ack.
// Backpressure: write-data underrun drops stb (cyc held); read data has none. Option: WB_MASTER_TIMEOUT_EN.
module wb_burst_master #(
    parameter int DW     = 32,
    parameter int AW     = 26,
    parameter int LEN_W  = 4,
    parameter int TO_CYC = 256
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_burst_master_if.master   bus
);
    localparam int BW = LEN_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [2:0]       cti_q, cti_d;
    logic [BW-1:0]    beats_q, beats_d;
    logic [DW-1:0]    rdat_q, rdat_d;
    logic             rdat_vld_q, rdat_vld_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             stb;
    logic             ack_hit;

    // Strobe follows write-data availability so an underrun becomes a master wait state.
    always_comb begin
        stb     = (state_q == S_BUS) && (we_q ? bus.wdat_valid : 1'b1);
        ack_hit = stb && bus.wb_ack_o;
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_hit;

    // Count consecutive strobed cycles without ack; the last such cycle aborts the burst.
    always_comb begin
        to_cnt_d = '0;
        to_hit   = 1'b0;
        if (stb && !bus.wb_ack_o) begin
            to_cnt_d = to_cnt_q + TW'(1);
            to_hit   = (to_cnt_q == TW'(TO_CYC - 1));
        end
    end

    // Timeout counter register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`else
    logic to_hit;
    logic unused_to_cyc;
    assign to_hit        = 1'b0;
    assign unused_to_cyc = (TO_CYC == 0);
`endif

    // Next-state logic: command latch, per-beat address/CTI advance, end-of-cycle pulses.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        addr_d     = addr_q;
        cti_d      = cti_q;
        beats_d    = beats_q;
        rdat_vld_d = ack_hit && !we_q;
        rdat_d     = (ack_hit && !we_q) ? bus.wb_dat_o : rdat_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    we_d    = bus.cmd_we;
                    addr_d  = bus.cmd_addr;
                    beats_d = {1'b0, bus.cmd_len} + BW'(1);
                    // A single beat is a classic cycle; a burst is never on its last beat here.
                    cti_d   = (bus.cmd_len == '0) ? 3'b000 : 3'b010;
                end
            end
            S_BUS: begin
                if (ack_hit) begin
                    addr_d  = addr_q + AW'(1);
                    beats_d = beats_q - BW'(1);
                    if (beats_q == BW'(1)) begin
                        state_d = S_DONE;
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                    end else if (cti_q != 3'b000) begin
                        cti_d = (beats_q == BW'(2)) ? 3'b111 : 3'b010;
                    end
                end else if (to_hit) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately without a done pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            cti_q      <= 3'b000;
            beats_q    <= '0;
            rdat_q     <= '0;
            rdat_vld_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            cti_q      <= cti_d;
            beats_q    <= beats_d;
            rdat_q     <= rdat_d;
            rdat_vld_q <= rdat_vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.wb_cyc_i   = cyc_q;
    assign bus.wb_stb_i   = stb;
    assign bus.wb_we_i    = we_q;
    assign bus.wb_addr_i  = addr_q;
    assign bus.wb_dat_i   = bus.wdat;
    assign bus.wb_sel_i   = we_q ? bus.wsel : '1;
    assign bus.wb_cti_i   = cti_q;
    assign bus.wdat_ready = ack_hit && we_q;
    assign bus.rdat       = rdat_q;
    assign bus.rdat_valid = rdat_vld_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed scenarios plus randomized commands vs. a beat-list model.
// Inputs change on the falling edge; outputs are sampled 1-2 time units later.
// Timeout scenario follows WB_MASTER_TIMEOUT_EN (TO_CYC=8 when enabled).
module tb_wb_burst_master;
    localparam int DW = 32, AW = 26, LEN_W = 4, TO_CYC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_burst_master_if #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) bus ();

    wb_burst_master #(.DW(DW), .AW(AW), .LEN_W(LEN_W), .TO_CYC(TO_CYC)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One command end to end. The model is a list of expected beats: address start+i
    // (mod 2^AW), CTI classic/incr/end, write data per beat, and read data queued one cycle.
    task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input int len,
                           input int dly, input int gap_beat, input int gap_len,
                           input bit rnd, input int abort_beat, input logic [31:0] d0);
        logic [AW-1:0] ea [16];
        logic [2:0]    ec [16];
        logic [31:0]   wd [16];
        logic [3:0]    ws [16];
        int  b = 0, w = 0, gap_done = 0, cycles = 0, nrdy = 0, cur_dly;
        bit  exp_stb, ack, prev_rd = 0, vld;
        logic [31:0] prev_data = '0;
        for (int i = 0; i <= len; i++) begin
            ea[i] = addr + AW'(i);
            ec[i] = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
            wd[i] = $urandom;
            ws[i] = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
        end
        if (d0 != 0) wd[0] = d0;
        cur_dly = (dly < 0) ? $urandom_range(0, 3) : dly;

        @(negedge clk);
        #1 chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LEN_W'(len);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_len   = LEN_W'($urandom);

        while (b <= len && cycles < 600) begin
            if (we) begin
                vld = 1'b1;
                if (b == gap_beat && gap_done < gap_len) begin
                    vld = 1'b0;
                    gap_done++;
                end else if (rnd && $urandom_range(0, 3) == 0) begin
                    vld = 1'b0;
                end
            end else begin
                vld = 1'($urandom_range(0, 1));
            end
            bus.wdat_valid = vld;
            bus.wdat       = wd[b];
            bus.wsel       = ws[b];
            bus.wb_dat_o   = $urandom;
            exp_stb        = we ? vld : 1'b1;
            ack            = exp_stb ? (w >= cur_dly) : (rnd && $urandom_range(0, 1) == 1);
            if (b == abort_beat && w == 1) begin
                bus.wb_ack_o = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("abort_cyc", 64'(bus.wb_cyc_i), 64'(0));
                chk("abort_stb", 64'(bus.wb_stb_i), 64'(0));
                chk("abort_done", 64'(bus.done), 64'(0));
                chk("abort_rdv", 64'(bus.rdat_valid), 64'(0));
                chk("abort_rdy", 64'(bus.cmd_ready), 64'(1));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            bus.wb_ack_o = ack;
            #1;
            chk("cyc", 64'(bus.wb_cyc_i), 64'(1));
            chk("stb", 64'(bus.wb_stb_i), 64'(exp_stb));
            chk("we", 64'(bus.wb_we_i), 64'(we));
            chk("addr", 64'(bus.wb_addr_i), 64'(ea[b]));
            chk("cti", 64'(bus.wb_cti_i), 64'(ec[b]));
            chk("wdat_ready", 64'(bus.wdat_ready), 64'(ack && exp_stb && we));
            chk("rdat_valid", 64'(bus.rdat_valid), 64'(prev_rd));
            if (prev_rd) chk("rdat", 64'(bus.rdat), 64'(prev_data));
            if (exp_stb && we) begin
                chk("wb_dat", 64'(bus.wb_dat_i), 64'(wd[b]));
                chk("wb_sel", 64'(bus.wb_sel_i), 64'(ws[b]));
            end
            if (exp_stb && !we) chk("rd_sel", 64'(bus.wb_sel_i), 64'(4'hF));
            chk("done_mid", 64'(bus.done), 64'(0));
            if (bus.wdat_ready) nrdy++;
            prev_rd   = ack && exp_stb && !we;
            prev_data = bus.wb_dat_o;
            if (ack && exp_stb) begin
                b++;
                w = 0;
                cur_dly = (dly < 0) ? $urandom_range(0, 3) : dly;
            end else if (exp_stb) begin
                w++;
            end
            @(negedge clk);
            cycles++;
        end
        chk("beats_done", 64'(b), 64'(len + 1));
        chk("wdat_ready_cnt", 64'(nrdy), we ? 64'(len + 1) : 64'(0));

        // Cycle after the last ack: done pulse, bus released, stray ack ignored.
        bus.wb_ack_o   = 1'($urandom_range(0, 1));
        bus.wdat_valid = 1'b0;
        #1;
        chk("done", 64'(bus.done), 64'(1));
        chk("err", 64'(bus.err), 64'(0));
        chk("done_cyc", 64'(bus.wb_cyc_i), 64'(0));
        chk("done_stb", 64'(bus.wb_stb_i), 64'(0));
        chk("done_rdy", 64'(bus.cmd_ready), 64'(0));
        chk("last_rdv", 64'(bus.rdat_valid), 64'(prev_rd));
        if (prev_rd) chk("last_rdat", 64'(bus.rdat), 64'(prev_data));
        @(negedge clk);
        bus.wb_ack_o = 1'b0;
        #1;
        chk("done_gone", 64'(bus.done), 64'(0));
        chk("idle_rdy", 64'(bus.cmd_ready), 64'(1));
        chk("idle_cyc", 64'(bus.wb_cyc_i), 64'(0));
        chk("idle_rdv", 64'(bus.rdat_valid), 64'(0));
    endtask

    initial begin
        int cyc_low;
        bus.cmd_valid  = 1'b0;
        bus.cmd_we     = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.wdat       = '0;
        bus.wsel       = '0;
        bus.wdat_valid = 1'b0;
        bus.wb_ack_o   = 1'b0;
        bus.wb_dat_o   = '0;

        // Reset held for two edges.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cyc", 64'(bus.wb_cyc_i), 64'(0));
        chk("rst_stb", 64'(bus.wb_stb_i), 64'(0));
        chk("rst_we", 64'(bus.wb_we_i), 64'(0));
        chk("rst_addr", 64'(bus.wb_addr_i), 64'(0));
        chk("rst_cti", 64'(bus.wb_cti_i), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_rdv", 64'(bus.rdat_valid), 64'(0));
        chk("rst_rdat", 64'(bus.rdat), 64'(0));
        chk("rst_wrdy", 64'(bus.wdat_ready), 64'(0));
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_cyc", 64'(bus.wb_cyc_i), 64'(0));
        chk("post_rst_rdy", 64'(bus.cmd_ready), 64'(1));

        // Directed scenarios.
        run_cmd(1'b1, 26'h100, 0, 0, -1, 0, 1'b0, -1, 32'hDEADBEEF);
        run_cmd(1'b0, 26'h3FFFFFE, 3, 0, -1, 0, 1'b0, -1, 32'h0);
        run_cmd(1'b1, 26'h2000, 7, 0, 2, 3, 1'b0, -1, 32'h0);
        run_cmd(1'b0, 26'h40, 1, 2, -1, 0, 1'b0, 1, 32'h0);

        // Slave never acks.
        @(negedge clk);
        #1 chk("to_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 26'h55;
        bus.cmd_len   = 4'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        for (int i = 0; i < TO_CYC; i++) begin
            #1 chk("to_stb", 64'(bus.wb_stb_i), 64'(1));
            @(negedge clk);
        end
        #1;
        chk("to_cyc_low", 64'(bus.wb_cyc_i), 64'(0));
        chk("to_stb_low", 64'(bus.wb_stb_i), 64'(0));
        chk("to_done", 64'(bus.done), 64'(1));
        chk("to_err", 64'(bus.err), 64'(1));
        @(negedge clk);
        #1;
        chk("to_err_gone", 64'(bus.err), 64'(0));
        chk("to_idle", 64'(bus.cmd_ready), 64'(1));
`else
        cyc_low = 0;
        for (int i = 0; i < 120; i++) begin
            #1 if (bus.wb_cyc_i !== 1'b1 || bus.wb_stb_i !== 1'b1 || bus.done !== 1'b0) cyc_low++;
            @(negedge clk);
        end
        chk("no_to_cyc_held", 64'(cyc_low), 64'(0));
        #1 chk("no_to_err", 64'(bus.err), 64'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("no_to_rst_cyc", 64'(bus.wb_cyc_i), 64'(0));
`endif

        // Randomized commands with random ack latency, write underruns and stray acks.
        for (int n = 0; n < 30; n++) begin
            run_cmd(1'($urandom_range(0, 1)), AW'($urandom), $urandom_range(0, 15),
                    -1, -1, 0, 1'b1, -1, 32'h0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
